// File: rtl/key_input_pkg.sv
// Shared state type, 50 MHz default timing and counter sizing for the KEY conditioner.
package key_input_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    HELD        = 3'd2,
    LONG        = 3'd3,
    DEB_RELEASE = 3'd4
  } key_state_t;

  localparam int CLK_FREQ_HZ         = 32'sd50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 32'sd1_000_000;   // 20 ms
  localparam int DEF_LONG_CYCLES     = 32'sd100_000_000; // 2 s
  localparam int DEF_REPEAT_CYCLES   = 32'sd10_000_000;  // 200 ms

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 32'sd1) ? 32'sd1 : $clog2(max_val + 32'sd1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: polarity-normalising 2-flop synchroniser, debounce/hold FSM, registered pulses.
// Auto-repeat timer is built only when KEY_AUTOREPEAT_EN is defined.
module key_channel
  import key_input_pkg::*;
#(
  parameter int ACTIVE_LOW      = 32'sd1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
`endif
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_key_n,
  output logic o_pressed,
  output logic o_press,
  output logic o_release,
  output logic o_tap,
  output logic o_long_press,
  output logic o_held_long,
  output logic o_repeat
);

  localparam int            HW       = cnt_width(LONG_CYCLES);
  localparam int            DW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam bit            DEB_ONE  = (DEBOUNCE_CYCLES == 32'sd1);

  logic          w_pin_act;
  logic          w_act;
  logic          r_sync1;
  logic          r_sync2;
  key_state_t    r_state;
  key_state_t    w_state_nx;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_nx;
  logic [HW-1:0] w_hold_inc;
  logic [DW-1:0] r_deb_cnt;
  logic [DW-1:0] w_deb_nx;
  logic [DW-1:0] w_deb_inc;
  logic          r_long;
  logic          w_long_nx;
  logic          w_press_nx;
  logic          w_release_nx;
  logic          w_tap_nx;
  logic          w_long_press_nx;
  logic          r_pressed;
  logic          r_press;
  logic          r_release;
  logic          r_tap;
  logic          r_long_press;

  // Normalise before synchronising so a cleared synchroniser always reads as released.
  assign w_pin_act  = (ACTIVE_LOW != 0) ? ~i_key_n : i_key_n;
  assign w_act      = r_sync2;
  assign w_hold_inc = (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + HW'(1'b1);
  assign w_deb_inc  = (r_deb_cnt == DEB_MAX) ? r_deb_cnt : r_deb_cnt + DW'(1'b1);

  // Next-state and pulse decode; the hold counter keeps running through a release bounce.
  always_comb begin
    w_state_nx      = r_state;
    w_hold_nx       = r_hold_cnt;
    w_deb_nx        = r_deb_cnt;
    w_long_nx       = r_long;
    w_press_nx      = 1'b0;
    w_release_nx    = 1'b0;
    w_tap_nx        = 1'b0;
    w_long_press_nx = 1'b0;
    case (r_state)
      IDLE: begin
        w_hold_nx = '0;
        w_deb_nx  = '0;
        w_long_nx = 1'b0;
        if (!w_act) begin
          w_state_nx = IDLE;
        end else if (DEB_ONE) begin
          w_state_nx = HELD;
          w_press_nx = 1'b1;
        end else begin
          w_state_nx = DEB_PRESS;
          w_deb_nx   = DW'(1'b1);
        end
      end
      DEB_PRESS: begin
        if (!w_act) begin
          w_state_nx = IDLE;
          w_deb_nx   = '0;
        end else if (w_deb_inc == DEB_MAX) begin
          w_state_nx = HELD;
          w_press_nx = 1'b1;
          w_deb_nx   = '0;
          w_hold_nx  = '0;
        end else begin
          w_deb_nx = w_deb_inc;
        end
      end
      HELD: begin
        w_hold_nx = w_hold_inc;
        if (w_hold_inc == HOLD_MAX) begin
          w_state_nx      = LONG;
          w_long_press_nx = 1'b1;
          w_long_nx       = 1'b1;
        end else if (w_act) begin
          w_state_nx = HELD;
        end else if (DEB_ONE) begin
          w_state_nx   = IDLE;
          w_release_nx = 1'b1;
          w_tap_nx     = 1'b1;
          w_hold_nx    = '0;
        end else begin
          w_state_nx = DEB_RELEASE;
          w_deb_nx   = DW'(1'b1);
        end
      end
      LONG: begin
        w_hold_nx = w_hold_inc;
        if (w_act) begin
          w_state_nx = LONG;
        end else if (DEB_ONE) begin
          w_state_nx   = IDLE;
          w_release_nx = 1'b1;
          w_long_nx    = 1'b0;
          w_hold_nx    = '0;
        end else begin
          w_state_nx = DEB_RELEASE;
          w_deb_nx   = DW'(1'b1);
        end
      end
      DEB_RELEASE: begin
        w_hold_nx = w_hold_inc;
        if (w_act) begin
          w_state_nx = r_long ? LONG : HELD;
          w_deb_nx   = '0;
        end else if (w_deb_inc == DEB_MAX) begin
          w_state_nx   = IDLE;
          w_release_nx = 1'b1;
          w_tap_nx     = ~r_long;
          w_long_nx    = 1'b0;
          w_deb_nx     = '0;
          w_hold_nx    = '0;
        end else begin
          w_deb_nx = w_deb_inc;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_hold_nx  = '0;
        w_deb_nx   = '0;
        w_long_nx  = 1'b0;
      end
    endcase
  end

  // Synchroniser, FSM registers and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_state      <= IDLE;
      r_hold_cnt   <= '0;
      r_deb_cnt    <= '0;
      r_long       <= 1'b0;
      r_pressed    <= 1'b0;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
      r_tap        <= 1'b0;
      r_long_press <= 1'b0;
    end else begin
      r_sync1      <= w_pin_act;
      r_sync2      <= r_sync1;
      r_state      <= w_state_nx;
      r_hold_cnt   <= w_hold_nx;
      r_deb_cnt    <= w_deb_nx;
      r_long       <= w_long_nx;
      r_pressed    <= (w_state_nx == HELD) || (w_state_nx == LONG) || (w_state_nx == DEB_RELEASE);
      r_press      <= w_press_nx;
      r_release    <= w_release_nx;
      r_tap        <= w_tap_nx;
      r_long_press <= w_long_press_nx;
    end
  end

  assign o_pressed    = r_pressed;
  assign o_press      = r_press;
  assign o_release    = r_release;
  assign o_tap        = r_tap;
  assign o_long_press = r_long_press;
  assign o_held_long  = r_long;

`ifdef KEY_AUTOREPEAT_EN
  localparam int            RW      = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES);

  logic [RW-1:0] r_rep_cnt;
  logic [RW-1:0] w_rep_inc;
  logic          w_rep_run;
  logic          w_rep_hit;
  logic          r_repeat;

  // Timer advances only while staying in LONG, so it freezes during a release bounce.
  always_comb begin
    w_rep_run = (r_state == LONG) && w_act;
    w_rep_inc = r_rep_cnt + RW'(1'b1);
    w_rep_hit = w_rep_run && (w_rep_inc == REP_MAX);
  end

  // Repeat timer and its registered pulse.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rep_cnt <= '0;
      r_repeat  <= 1'b0;
    end else begin
      r_repeat <= w_rep_hit;
      if (w_state_nx == IDLE) begin
        r_rep_cnt <= '0;
      end else if (w_rep_run) begin
        r_rep_cnt <= w_rep_hit ? '0 : w_rep_inc;
      end else begin
        r_rep_cnt <= r_rep_cnt;
      end
    end
  end

  assign o_repeat = r_repeat;
`else
  assign o_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_input_conditioner.sv
// Multi-channel push-button conditioner: one key_channel per KEY pin plus parameter legality checks.
// Define KEY_AUTOREPEAT_EN to build the per-channel auto-repeat timer; otherwise o_repeat is 0.
module key_input_conditioner
  import key_input_pkg::*;
#(
  parameter int CHANNELS        = 32'sd4,
  parameter int ACTIVE_LOW      = 32'sd1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [CHANNELS-1:0] i_key_n,
  output logic [CHANNELS-1:0] o_pressed,
  output logic [CHANNELS-1:0] o_press,
  output logic [CHANNELS-1:0] o_release,
  output logic [CHANNELS-1:0] o_tap,
  output logic [CHANNELS-1:0] o_long_press,
  output logic [CHANNELS-1:0] o_held_long,
  output logic [CHANNELS-1:0] o_repeat
);

  if (CHANNELS < 32'sd1) begin : g_bad_channels
    $error("key_input_conditioner: CHANNELS must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 32'sd1) begin : g_bad_debounce
    $error("key_input_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("key_input_conditioner: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (REPEAT_CYCLES < 32'sd1) begin : g_bad_repeat
    $error("key_input_conditioner: REPEAT_CYCLES must be >= 1");
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    key_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
    ) u_ch (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_key_n      (i_key_n[g]),
      .o_pressed    (o_pressed[g]),
      .o_press      (o_press[g]),
      .o_release    (o_release[g]),
      .o_tap        (o_tap[g]),
      .o_long_press (o_long_press[g]),
      .o_held_long  (o_held_long[g]),
      .o_repeat     (o_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_input_conditioner.sv
// Self-checking bench: directed timing scenarios plus randomized pins against a level/run/age reference model.
module tb_key_input_conditioner;

  localparam int CH  = 4;
  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] key_n;
  logic [CH-1:0] o_pressed, o_press, o_release, o_tap, o_long_press, o_held_long, o_repeat;

  always #5 clk = ~clk;

  key_input_conditioner #(
    .CHANNELS(CH), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG), .REPEAT_CYCLES(REP)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_key_n(key_n),
    .o_pressed(o_pressed), .o_press(o_press), .o_release(o_release), .o_tap(o_tap),
    .o_long_press(o_long_press), .o_held_long(o_held_long), .o_repeat(o_repeat)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: accepted level, run of disagreeing samples, hold age, long flag.
  bit m_s1[CH], m_s2[CH], m_level[CH], m_long[CH];
  int m_run[CH], m_age[CH], m_rep[CH];
  logic [CH-1:0] e_pressed, e_press, e_release, e_tap, e_long, e_held, e_rpt;

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      bit act;
      int age_n;
      act = m_s2[c];
      e_press[c] = 1'b0; e_release[c] = 1'b0; e_tap[c] = 1'b0; e_long[c] = 1'b0; e_rpt[c] = 1'b0;
      if (rst) begin
        m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_level[c] = 1'b0; m_long[c] = 1'b0;
        m_run[c] = 0; m_age[c] = 0; m_rep[c] = 0;
      end else begin
        m_s2[c] = m_s1[c];
        m_s1[c] = ~key_n[c];
        if (!m_level[c]) begin
          if (act) begin
            m_run[c]++;
            if (m_run[c] >= DEB) begin
              m_level[c] = 1'b1; m_run[c] = 0; m_age[c] = 0; e_press[c] = 1'b1;
            end
          end else begin
            m_run[c] = 0;
          end
        end else begin
          age_n = (m_age[c] + 1 > LNG) ? LNG : m_age[c] + 1;
          if (!m_long[c] && m_run[c] == 0 && age_n >= LNG) begin
            m_long[c] = 1'b1; e_long[c] = 1'b1; m_rep[c] = 0;
          end else if (act) begin
            if (m_long[c] && m_run[c] == 0) begin
              m_rep[c]++;
              if (m_rep[c] == REP) begin
                m_rep[c] = 0;
`ifdef KEY_AUTOREPEAT_EN
                e_rpt[c] = 1'b1;
`endif
              end
            end
            m_run[c] = 0;
          end else begin
            m_run[c]++;
            if (m_run[c] >= DEB) begin
              e_release[c] = 1'b1; e_tap[c] = ~m_long[c];
              m_level[c] = 1'b0; m_long[c] = 1'b0; m_run[c] = 0; m_rep[c] = 0;
            end
          end
          m_age[c] = age_n;
        end
      end
      e_pressed[c] = m_level[c];
      e_held[c]    = m_long[c];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_eq("pressed",    32'(o_pressed),    32'(e_pressed));
    check_eq("press",      32'(o_press),      32'(e_press));
    check_eq("release",    32'(o_release),    32'(e_release));
    check_eq("tap",        32'(o_tap),        32'(e_tap));
    check_eq("long_press", 32'(o_long_press), 32'(e_long));
    check_eq("held_long",  32'(o_held_long),  32'(e_held));
    check_eq("repeat",     32'(o_repeat),     32'(e_rpt));
  endtask

  // Directed scenario bookkeeping: event index 0 press, 1 release, 2 tap, 3 long, 4 repeat.
  int ev_first[5], ev_second[5], ev_cnt[5], rep_cyc[8];
  int rep_n;
  bit saw_pressed, held_at30, zero_at_11;

  function automatic logic [CH-1:0] pat(input int id, input int k);
    logic [CH-1:0] p;
    p = '1;
    case (id)
      1:       p[1] = (k >= 10);
      2:       p[2] = (k < 12) ? ((k / 2) % 2 == 1) : 1'b1;
      3:       p[0] = (k >= 40);
      4:       p[0] = (k >= 30) || (k == 15) || (k == 16);
      5:       p[3] = (k >= 40);
      default: p[0] = (k >= 45);
    endcase
    return p;
  endfunction

  task automatic note(input int cy, input int ch);
    logic [4:0] ev;
    ev = {o_repeat[ch], o_long_press[ch], o_tap[ch], o_release[ch], o_press[ch]};
    for (int i = 0; i < 5; i++) begin
      if (ev[i]) begin
        if (ev_cnt[i] == 0) ev_first[i] = cy;
        else if (ev_cnt[i] == 1) ev_second[i] = cy;
        ev_cnt[i]++;
      end
    end
    if (o_repeat[ch] && rep_n < 8) begin
      rep_cyc[rep_n] = cy;
      rep_n++;
    end
    if (o_pressed[ch]) saw_pressed = 1'b1;
    if (cy == 30) held_at30 = o_held_long[ch];
    if (cy == 11) zero_at_11 = ({o_pressed, o_press, o_release, o_tap, o_long_press, o_held_long, o_repeat} == '0);
  endtask

  task automatic run_scn(input int id, input int ch, input int n);
    for (int i = 0; i < 5; i++) begin
      ev_first[i] = -1; ev_second[i] = -1; ev_cnt[i] = 0;
    end
    for (int i = 0; i < 8; i++) rep_cyc[i] = -1;
    rep_n = 0; saw_pressed = 1'b0; held_at30 = 1'b0; zero_at_11 = 1'b0;
    for (int k = 0; k < n; k++) begin
      key_n = pat(id, k);
      rst   = (id == 5 && k == 10);
      step();
      note(k + 1, ch);
    end
  endtask

  int  seg_left[CH];
  bit  lvl[CH];

  initial begin
    rst   = 1'b1;
    key_n = '1;
    step();
    step();
    check_eq("reset_state", 32'({o_pressed, o_press, o_release, o_tap, o_long_press, o_held_long, o_repeat}), 32'd0);
    rst = 1'b0;
    step();
    step();

    // Short press on KEY[1]: tap, no long.
    run_scn(1, 1, 30);
    check_eq("s1_press_cycle",   ev_first[0], 32'd6);
    check_eq("s1_press_count",   ev_cnt[0],   32'd1);
    check_eq("s1_release_cycle", ev_first[1], 32'd16);
    check_eq("s1_tap_cycle",     ev_first[2], 32'd16);
    check_eq("s1_long_count",    ev_cnt[3],   32'd0);

    // Bouncing KEY[2] never accepted.
    cyc = cyc;
    run_scn(2, 2, 24);
    check_eq("s2_press_count",   ev_cnt[0], 32'd0);
    check_eq("s2_release_count", ev_cnt[1], 32'd0);
    check_eq("s2_tap_count",     ev_cnt[2], 32'd0);
    check_eq("s2_pressed_seen",  32'(saw_pressed), 32'd0);

    // Long hold on KEY[0].
    run_scn(3, 0, 60);
    check_eq("s3_press_cycle",   ev_first[0], 32'd6);
    check_eq("s3_long_cycle",    ev_first[3], 32'd26);
    check_eq("s3_held_long_30",  32'(held_at30), 32'd1);
    check_eq("s3_release_cycle", ev_first[1], 32'd46);
    check_eq("s3_tap_count",     ev_cnt[2],   32'd0);

    // Release glitch during hold does not restart the hold timer.
    run_scn(4, 0, 50);
    check_eq("s4_press_count",   ev_cnt[0],   32'd1);
    check_eq("s4_long_cycle",    ev_first[3], 32'd26);
    check_eq("s4_release_cycle", ev_first[1], 32'd36);
    check_eq("s4_release_count", ev_cnt[1],   32'd1);

    // Reset mid-hold on KEY[3]; key must re-debounce.
    run_scn(5, 3, 60);
    check_eq("s5_zero_after_reset", 32'(zero_at_11), 32'd1);
    check_eq("s5_press_first",      ev_first[0],  32'd6);
    check_eq("s5_press_refire",     ev_second[0], 32'd17);

    // Auto-repeat on a 45-cycle hold of KEY[0].
    run_scn(6, 0, 64);
    check_eq("s6_release_cycle", ev_first[1], 32'd51);
`ifdef KEY_AUTOREPEAT_EN
    check_eq("s6_repeat_count", ev_cnt[4],  32'd4);
    check_eq("s6_repeat_0",     rep_cyc[0], 32'd31);
    check_eq("s6_repeat_1",     rep_cyc[1], 32'd36);
    check_eq("s6_repeat_2",     rep_cyc[2], 32'd41);
    check_eq("s6_repeat_3",     rep_cyc[3], 32'd46);
`else
    check_eq("s6_repeat_count", ev_cnt[4],  32'd0);
`endif

    // Randomized pins: stable segments mixed with short bounces, rare resets.
    for (int c = 0; c < CH; c++) begin
      seg_left[c] = 0;
      lvl[c]      = 1'b0;
    end
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++) begin
        if (seg_left[c] == 0) begin
          lvl[c]      = ~lvl[c];
          seg_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 60));
        end
        seg_left[c]--;
        key_n[c] = ~lvl[c];
      end
      rst = ($urandom_range(0, 399) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
